// File: rtl/minisys_pkg.sv
// Shared minisys fetch definitions: state encoding, reset PC and word alignment.
// FETCH_MISALIGN_TRAP_EN adds the FAULT state used by the jr-misalignment trap.
package minisys_pkg;

    localparam logic [31:0] MINISYS_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_HOLD  = 3'd2,
        ST_FLUSH = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
        , ST_FAULT = 3'd4
`endif
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_target_sel.sv
// Combinational redirect decision and target mux for the execute-stage control-flow result.
// The jr target is always word-aligned here; misaligned_o reports what was discarded.
module ifetch_target_sel
    import minisys_pkg::*;
(
    input  logic        redirect_valid_i,
    input  logic        branch_i,
    input  logic        nbranch_i,
    input  logic        jmp_i,
    input  logic        jal_i,
    input  logic        jrn_i,
    input  logic        zero_i,
    input  logic [31:0] add_result_i,
    input  logic [25:0] jump_index_i,
    input  logic [31:0] exe_pc_plus_4_i,
    input  logic [31:0] read_data_1_i,
    output logic        taken_o,
    output logic [31:0] target_o,
    output logic        misaligned_o
);

    logic unused_bits;
    assign unused_bits = ^{add_result_i[31:30], exe_pc_plus_4_i[27:0]};

    assign taken_o = redirect_valid_i &
                     (jrn_i | jmp_i | jal_i | (branch_i & zero_i) | (nbranch_i & ~zero_i));

    assign misaligned_o = redirect_valid_i & jrn_i & (|read_data_1_i[1:0]);

    always_comb begin
        target_o = {add_result_i[29:0], 2'b00};
        if (jrn_i) begin
            target_o = word_align(read_data_1_i);
        end else if (jmp_i || jal_i) begin
            target_o = {exe_pc_plus_4_i[31:28], jump_index_i, 2'b00};
        end
    end

endmodule

// File: rtl/ifetch_seq.sv
// Sequential instruction fetch: owns the PC, drives the req/ack imem port and hands words to decode.
// Build option FETCH_MISALIGN_TRAP_EN traps a misaligned jr target into a sticky FAULT state.
module ifetch_seq
    import minisys_pkg::*;
#(
    parameter logic [31:0] RESET_PC = MINISYS_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] Imem_addr,
    output logic        Imem_req,
    input  logic        Imem_ack,
    input  logic [31:0] Imem_rdata,
    output logic [31:0] Instruction,
    output logic        Inst_valid,
    input  logic        Inst_ready,
    output logic [31:0] PC_plus_4,
    input  logic        Redirect_valid,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jrn,
    input  logic        Zero,
    input  logic [31:0] Add_Result,
    input  logic [25:0] Jump_index,
    input  logic [31:0] Exe_PC_plus_4,
    input  logic [31:0] Read_data_1,
    output logic [31:0] opcplus4,
    output logic        Fetch_fault,
    output logic [2:0]  dbg_state
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fa_q, fa_d, npc_q, npc_d;
    logic [31:0]  instr_q, instr_d, pcp4_q, pcp4_d, link_q, link_d;
    logic         valid_q, valid_d;
    logic         taken, misaligned, can_redirect;
    logic [31:0]  target;

    ifetch_target_sel u_target_sel (
        .redirect_valid_i (Redirect_valid),
        .branch_i         (Branch),
        .nbranch_i        (nBranch),
        .jmp_i            (Jmp),
        .jal_i            (Jal),
        .jrn_i            (Jrn),
        .zero_i           (Zero),
        .add_result_i     (Add_Result),
        .jump_index_i     (Jump_index),
        .exe_pc_plus_4_i  (Exe_PC_plus_4),
        .read_data_1_i    (Read_data_1),
        .taken_o          (taken),
        .target_o         (target),
        .misaligned_o     (misaligned)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    assign can_redirect = (state_q != ST_FAULT);
    assign Fetch_fault  = (state_q == ST_FAULT);
`else
    logic unused_misalign;
    assign unused_misalign = misaligned;
    assign can_redirect    = 1'b1;
    assign Fetch_fault     = 1'b0;
`endif

    // Both ports transfer on valid&ready (req&ack) in the same cycle; a request, once raised,
    // keeps its address until acked, and a held word stays put until accepted or squashed.
    assign Imem_req    = (state_q == ST_REQ) || (state_q == ST_FLUSH);
    assign Imem_addr   = fa_q;
    assign Instruction = instr_q;
    assign Inst_valid  = valid_q;
    assign PC_plus_4   = pcp4_q;
    assign opcplus4    = link_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d = state_q;
        fa_d    = fa_q;
        npc_d   = npc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        link_d  = link_q;
        case (state_q)
            ST_IDLE: begin
                fa_d    = RESET_PC;
                npc_d   = RESET_PC;
                state_d = ST_REQ;
            end
            ST_REQ: if (Imem_ack) begin
                instr_d = Imem_rdata;
                pcp4_d  = fa_q + 32'd4;
                npc_d   = fa_q + 32'd4;
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: if (valid_q && Inst_ready) begin
                fa_d    = npc_q;
                valid_d = 1'b0;
                state_d = ST_REQ;
            end
            ST_FLUSH: if (Imem_ack) begin
                fa_d    = npc_q;
                state_d = ST_REQ;
            end
            default: state_d = state_q;
        endcase

        // A taken redirect overrides whatever the state decided, including a same-cycle ack.
        if (taken && can_redirect) begin
            npc_d   = target;
            valid_d = 1'b0;
            instr_d = instr_q;
            pcp4_d  = pcp4_q;
            if (Jal) link_d = Exe_PC_plus_4;
            if (Imem_req && !Imem_ack) begin
                state_d = ST_FLUSH;
            end else begin
                fa_d    = target;
                state_d = ST_REQ;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) state_d = ST_FAULT;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fa_q    <= RESET_PC;
            npc_q   <= RESET_PC;
            instr_q <= '0;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
            link_q  <= '0;
        end else begin
            state_q <= state_d;
            fa_q    <= fa_d;
            npc_q   <= npc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            link_q  <= link_d;
        end
    end

endmodule

// File: tb/tb_ifetch_seq.sv
// Directed bench for ifetch_seq: expected fetches and presented words go into queues, a negedge monitor checks them.
module tb_ifetch_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] Imem_addr;
  logic        Imem_req;
  logic        Imem_ack;
  logic [31:0] Imem_rdata;
  logic [31:0] Instruction;
  logic        Inst_valid;
  logic        Inst_ready;
  logic [31:0] PC_plus_4;
  logic        Redirect_valid, Branch, nBranch, Jmp, Jal, Jrn, Zero;
  logic [31:0] Add_Result;
  logic [25:0] Jump_index;
  logic [31:0] Exe_PC_plus_4;
  logic [31:0] Read_data_1;
  logic [31:0] opcplus4;
  logic        Fetch_fault;
  logic [2:0]  dbg_state;
  logic        ack_en;

  ifetch_seq dut (
    .clock(clock), .reset(reset),
    .Imem_addr(Imem_addr), .Imem_req(Imem_req), .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata),
    .Instruction(Instruction), .Inst_valid(Inst_valid), .Inst_ready(Inst_ready), .PC_plus_4(PC_plus_4),
    .Redirect_valid(Redirect_valid), .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal),
    .Jrn(Jrn), .Zero(Zero), .Add_Result(Add_Result), .Jump_index(Jump_index),
    .Exe_PC_plus_4(Exe_PC_plus_4), .Read_data_1(Read_data_1),
    .opcplus4(opcplus4), .Fetch_fault(Fetch_fault), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // memory model: word content is derived from its address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign Imem_ack   = Imem_req & ack_en;
  assign Imem_rdata = mem_word(Imem_addr);

  // scoreboard
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_dec_q[$];
  int n_checks = 0;
  int n_pass = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (Imem_req && Imem_ack) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_fetch: got addr %h expected no fetch at %0t", Imem_addr, $time);
        end else begin
          chk("fetch_addr", {32'h0, Imem_addr}, {32'h0, exp_addr_q.pop_front()});
        end
      end
      if (Inst_valid && !prev_valid) begin
        if (exp_dec_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got %h/%h expected none at %0t", Instruction, PC_plus_4, $time);
        end else begin
          chk("decode_word", {Instruction, PC_plus_4}, exp_dec_q.pop_front());
        end
      end
    end
    prev_valid <= Inst_valid;
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_redirect();
    Redirect_valid = 0; Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jrn = 0; Zero = 0;
    Add_Result = '0; Jump_index = '0; Exe_PC_plus_4 = '0; Read_data_1 = '0;
  endtask

  task automatic expect_fetch(input logic [31:0] a, input bit presented);
    exp_addr_q.push_back(a);
    if (presented) exp_dec_q.push_back({mem_word(a), a + 32'd4});
  endtask

  initial begin
    clear_redirect();
    reset = 1'b1; Inst_ready = 1'b1; ack_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req", Imem_req, 0);
    chk("rst_addr", Imem_addr, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_valid", Inst_valid, 0);
    chk("rst_pcp4", PC_plus_4, 32'h0);
    chk("rst_link", opcplus4, 32'h0);
    chk("rst_fault", Fetch_fault, 0);

    // sequential fetch, zero-wait memory, decode always ready; word 0x8 is later squashed
    expect_fetch(32'h0, 1); expect_fetch(32'h4, 1); expect_fetch(32'h8, 1);
    reset = 1'b0;
    step(); chk("seq_req1", Imem_req, 1); chk("seq_addr1", Imem_addr, 32'h0);
    step(); chk("seq_valid1", Inst_valid, 1); chk("seq_req_off", Imem_req, 0);
    step(); chk("seq_addr2", Imem_addr, 32'h4);
    step();
    step(); chk("seq_addr3", Imem_addr, 32'h8);
    step(); chk("seq_pcp4_3", PC_plus_4, 32'hC);

    // beq taken in HOLD while decode is ready: word squashed, refetch at 0x40
    expect_fetch(32'h40, 1);
    Redirect_valid = 1; Branch = 1; Zero = 1; Add_Result = 32'h10;
    step(); clear_redirect(); Inst_ready = 0;
    chk("beq_squash", Inst_valid, 0); chk("beq_req", Imem_req, 1); chk("beq_addr", Imem_addr, 32'h40);
    step();

    // j redirect while the 0x44 request waits 3 cycles: old address held, word dropped, then 0x400
    expect_fetch(32'h44, 0); expect_fetch(32'h400, 1);
    Inst_ready = 1; ack_en = 0;
    step(); Inst_ready = 0;
    Redirect_valid = 1; Jmp = 1; Jump_index = 26'h100; Exe_PC_plus_4 = 32'h48;
    step(); clear_redirect();
    chk("flush_addr_a", Imem_addr, 32'h44); chk("flush_req", Imem_req, 1);
    step(); chk("flush_addr_b", Imem_addr, 32'h44);
    ack_en = 1;
    step(); chk("flush_next", Imem_addr, 32'h400);
    step();

    // jal from HOLD: link captured, fetch at 0x80
    expect_fetch(32'h80, 1);
    Redirect_valid = 1; Jal = 1; Jump_index = 26'h20; Exe_PC_plus_4 = 32'h24;
    step(); clear_redirect();
    chk("jal_link", opcplus4, 32'h24); chk("jal_addr", Imem_addr, 32'h80);
    step();

    // bne with Zero=1 is not taken: sequential fetch continues at 0x84
    expect_fetch(32'h84, 1);
    Redirect_valid = 1; nBranch = 1; Zero = 1; Add_Result = 32'h999; Inst_ready = 1;
    step(); clear_redirect(); Inst_ready = 0;
    chk("bne_nt_addr", Imem_addr, 32'h84); chk("bne_link", opcplus4, 32'h24);
    step();

    // branch in the same cycle as the 0x88 ack: word dropped, refetch 0xC0
    expect_fetch(32'h88, 0); expect_fetch(32'hC0, 1);
    Inst_ready = 1;
    step(); Inst_ready = 0;
    Redirect_valid = 1; Branch = 1; Zero = 1; Add_Result = 32'h30;
    step(); clear_redirect();
    chk("ackdrop_addr", Imem_addr, 32'hC0); chk("ackdrop_valid", Inst_valid, 0);
    step();

    // reset in the middle of an outstanding request
    Inst_ready = 1; ack_en = 0;
    step(); chk("midrst_req_before", Imem_req, 1);
    #2 reset = 1'b1;
    #1 chk("midrst_req", Imem_req, 0); chk("midrst_addr", Imem_addr, 32'h0);
    chk("midrst_link", opcplus4, 32'h0);
    Inst_ready = 0; ack_en = 1;
    expect_fetch(32'h0, 1);
    step(); reset = 1'b0;
    step(); chk("restart_addr", Imem_addr, 32'h0); chk("restart_req", Imem_req, 1);
    step();

    // jr to a misaligned target
    Redirect_valid = 1; Jrn = 1; Read_data_1 = 32'h102;
`ifdef FETCH_MISALIGN_TRAP_EN
    step(); clear_redirect();
    chk("jr_fault", Fetch_fault, 1); chk("jr_fault_req", Imem_req, 0);
    Inst_ready = 1;
    repeat (3) step();
    chk("jr_fault_sticky", Fetch_fault, 1); chk("jr_fault_noreq", Imem_req, 0);
    chk("jr_fault_novalid", Inst_valid, 0);
`else
    expect_fetch(32'h100, 1);
    step(); clear_redirect();
    chk("jr_align_addr", Imem_addr, 32'h100); chk("jr_nofault", Fetch_fault, 0);
    step();
`endif

    step(); step();
    chk("addr_queue_drained", exp_addr_q.size(), 0);
    chk("word_queue_drained", exp_dec_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_seq.md
# ifetch_seq

Sequential instruction-fetch unit for the minisys single-issue core. It consumes the control-flow results produced by the execute stage (word-address branch target, Zero flag, jump/jr/jal qualifiers), owns the program counter, and drives a request/acknowledge instruction-memory port. Fetched words are presented to decode through a valid/ready handshake. It also latches the jal link value for writeback.

## Interface
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset (word-aligned)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- Imem_addr  out  32  byte address of the outstanding fetch; stable while Imem_req=1
- Imem_req  out  1  fetch request; held until Imem_ack
- Imem_ack  in  1  memory accepted and returned Imem_rdata this cycle
- Imem_rdata  in  32  instruction word, valid when Imem_ack=1
- Instruction  out  32  held instruction to decode
- Inst_valid  out  1  Instruction and PC_plus_4 valid
- Inst_ready  in  1  decode accepts Instruction this cycle
- PC_plus_4  out  32  byte address of held instruction + 4
- Redirect_valid  in  1  execute resolves a control-flow instruction this cycle
- Branch, nBranch, Jmp, Jal, Jrn  in  1 each  execute-stage qualifiers (beq, bne, j, jal, jr)
- Zero  in  1  execute Zero flag
- Add_Result  in  32  branch target, word address (PC_plus_4[31:2] + offset)
- Jump_index  in  26  instr[25:0] of the resolving instruction
- Exe_PC_plus_4  in  32  PC+4 of the resolving instruction
- Read_data_1  in  32  jr target (byte address)
- opcplus4  out  32  jal link value
- Fetch_fault  out  1  misaligned jr target (see Configuration)

## Operation
- States: IDLE, REQ, HOLD, FLUSH, FAULT. Registers: fetch address FA, next PC NPC.
- IDLE: one cycle after reset release -> REQ; FA=NPC=RESET_PC.
- REQ: Imem_req=1, Imem_addr=FA. On Imem_ack: Instruction<=Imem_rdata, PC_plus_4<=FA+4, NPC<=FA+4, Inst_valid<=1 -> HOLD.
- HOLD: Imem_req=0. Inst_valid&Inst_ready -> FA<=NPC, Inst_valid<=0, -> REQ.
- Redirect taken = Redirect_valid & (Jrn | Jmp | Jal | (Branch&Zero) | (nBranch&~Zero)). Redirect_valid without a taken condition is ignored.
- Target priority: Jrn -> Read_data_1; Jmp/Jal -> {Exe_PC_plus_4[31:28], Jump_index, 2'b00}; branch -> {Add_Result[29:0], 2'b00}. Sums are 32-bit, wrap modulo 2^32.
- Taken redirect: NPC<=target; Inst_valid<=0 (squashes held word even if Inst_ready=1 same cycle). From IDLE/HOLD -> REQ with FA<=target. From REQ with Imem_ack this cycle: data dropped, -> REQ with FA<=target. From REQ without ack -> FLUSH.
- FLUSH: Imem_req=1, Imem_addr=old FA (request never withdrawn). On ack: data dropped, FA<=NPC -> REQ. Further redirects in FLUSH overwrite NPC (latest wins).
- Jal redirect additionally: opcplus4<=Exe_PC_plus_4.

## Timing
- Reset values: Imem_req=0, Imem_addr=RESET_PC, Instruction=0, Inst_valid=0, PC_plus_4=0, opcplus4=0, Fetch_fault=0, state IDLE. Reset mid-request drops Imem_req immediately; memory abandons.
- Imem_ack may arrive in the request's first cycle (zero-wait memory). Best case: reset release -> Imem_req at cycle 1 -> Inst_valid at cycle 2.
- Steady throughput: one instruction per 2 cycles plus memory wait states.
- Redirect-to-request latency: 1 cycle (2+ if FLUSH must drain).

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: taken Jrn with Read_data_1[1:0]!=0 -> FAULT; Fetch_fault=1, Imem_req=0, Inst_valid=0 until reset. Other targets cannot misalign.
- Undefined: Read_data_1[1:0] forced to 0; Fetch_fault tied 0; FAULT state absent.

## Structure
- Shared package minisys_pkg: fetch state enum, default RESET_PC constant, word-align helper.
- Sub-module ifetch_target_sel: combinational taken decision and target mux (qualifiers, Zero, Add_Result, Jump_index, Exe_PC_plus_4, Read_data_1 -> taken, target, misaligned).

## Test plan
- Reset release, ack held 1, Inst_ready held 1 -> Imem_addr sequence 0x0,0x4,0x8 at one request per 2 cycles; PC_plus_4 0x4,0x8,0xC.
- HOLD with Branch=1, Zero=1, Add_Result=0x0000_0010, Redirect_valid=1, Inst_ready=1 -> Inst_valid drops, next Imem_addr=0x40.
- REQ at 0x8, ack delayed 3 cycles, Jmp redirect Jump_index=0x100 in cycle 1 -> Imem_addr stays 0x8 until ack, word dropped, next request 0x400.
- Jal redirect with Exe_PC_plus_4=0x24 -> opcplus4=0x24; bne with Zero=1 -> no redirect, fetch continues sequentially.
- Jrn, Read_data_1=0x102: with FETCH_MISALIGN_TRAP_EN -> Fetch_fault=1, no further Imem_req; without -> fetch at 0x100.
- Reset asserted while Imem_req=1 -> Imem_req=0 same cycle; after release first fetch at RESET_PC.
